// File: rtl/snf_rxreq_pkg.sv
// Shared CHI REQ-channel types and constants for the SN-F request receiver.
package snf_rxreq_pkg;

  localparam int unsigned NODE_ID_W = 7;
  localparam int unsigned TXN_ID_W  = 8;
  localparam int unsigned OPCODE_W  = 6;
  localparam int unsigned ADDR_W    = 44;
  localparam int unsigned QOS_W     = 4;
  localparam int unsigned CNT_W     = 4;

  localparam int unsigned NUM_CREDITS_FOR_SN_REQ = 4;

  localparam logic [OPCODE_W-1:0] REQ_LCRD_RETURN       = 6'h00;
  localparam logic [OPCODE_W-1:0] REQ_READ_NO_SNP       = 6'h04;
  localparam logic [OPCODE_W-1:0] REQ_WRITE_NO_SNP_FULL = 6'h1D;

  typedef struct packed {
    logic [QOS_W-1:0]     qos;
    logic [NODE_ID_W-1:0] tgt_id;
    logic [NODE_ID_W-1:0] src_id;
    logic [TXN_ID_W-1:0]  txn_id;
    logic [OPCODE_W-1:0]  opcode;
    logic [ADDR_W-1:0]    addr;
  } reqflit_t;

  function automatic logic is_lcrd_return(input reqflit_t f);
    return f.opcode == REQ_LCRD_RETURN;
  endfunction

endpackage

// File: rtl/sfifo.sv
// Synchronous first-word-fall-through FIFO with registered empty/full flags.
module sfifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic [CNT_W-1:0] count_nxt;

  assign do_wr     = wr_en && !full;
  assign do_rd     = rd_en && !empty;
  assign count_nxt = count + CNT_W'(do_wr) - CNT_W'(do_rd);
  assign rd_data   = mem[rd_ptr];

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/snf_rxreq.sv
// SN-F receive side of the HN-F REQ channel: L-credit issue, flit buffering, link state.
// Optional TgtID filtering is enabled by defining SNF_RXREQ_TGTID_CHECK_EN.
module snf_rxreq
  import snf_rxreq_pkg::*;
#(
  parameter int unsigned          NUM_CREDITS = NUM_CREDITS_FOR_SN_REQ,
  parameter logic [NODE_ID_W-1:0] SN_ID       = '0
) (
  input  logic     clock,
  input  logic     rst_n,
  input  logic     rxreqflitpend,
  input  logic     rxreqflitv,
  input  reqflit_t rxreqflit,
  output logic     rxreqlcrdv,
  input  logic     link_active,
  output logic     link_stopped,
  output reqflit_t req_out,
  output logic     req_out_v,
  input  logic     req_out_rdy,
  output logic     err_overrun
`ifdef SNF_RXREQ_TGTID_CHECK_EN
  ,
  output logic     err_tgtid
`endif
);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DEACT = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] crd_out;
  logic [CNT_W-1:0] crd_nxt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W:0]   committed;
  logic             lcrdv_nxt;
  logic             flit_take;
  logic             flit_enq;
  logic             overrun_set;
  logic             tgt_ok;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             unused_sink;

`ifdef SNF_RXREQ_TGTID_CHECK_EN
  assign tgt_ok = (rxreqflit.tgt_id == SN_ID);
`else
  assign tgt_ok = 1'b1;
`endif

  assign unused_sink = ^{rxreqflitpend, fifo_full, SN_ID};

  assign flit_take   = rxreqflitv && (crd_out != '0);
  assign overrun_set = rxreqflitv && (crd_out == '0);
  assign flit_enq    = flit_take && !is_lcrd_return(rxreqflit) && tgt_ok;
  assign req_out_v   = !fifo_empty;
  assign pop         = req_out_v && req_out_rdy;
  assign crd_nxt     = crd_out + CNT_W'(rxreqlcrdv) - CNT_W'(flit_take);

  // Slots already spoken for after this cycle; a pop frees its slot for next cycle's grant.
  assign committed = (CNT_W+1)'(crd_out) + (CNT_W+1)'(fifo_cnt)
                   + (CNT_W+1)'(rxreqlcrdv) - (CNT_W+1)'(pop);

  always_comb begin
    state_nxt = state;
    lcrdv_nxt = 1'b0;
    case (state)
      ST_STOP:  if (link_active) state_nxt = ST_RUN;
      ST_RUN:   if (!link_active) state_nxt = ST_DEACT;
      ST_DEACT: begin
        if (link_active)         state_nxt = ST_RUN;
        else if (crd_nxt == '0)  state_nxt = ST_STOP;
      end
      default:  state_nxt = ST_STOP;
    endcase
    if ((state == ST_RUN) && link_active && (committed < (CNT_W+1)'(NUM_CREDITS)))
      lcrdv_nxt = 1'b1;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_STOP;
      crd_out      <= '0;
      rxreqlcrdv   <= 1'b0;
      link_stopped <= 1'b1;
      err_overrun  <= 1'b0;
    end else begin
      state        <= state_nxt;
      crd_out      <= crd_nxt;
      rxreqlcrdv   <= lcrdv_nxt;
      link_stopped <= (state_nxt == ST_STOP);
      if (overrun_set) err_overrun <= 1'b1;
    end
  end

`ifdef SNF_RXREQ_TGTID_CHECK_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                                                err_tgtid <= 1'b0;
    else if (flit_take && !is_lcrd_return(rxreqflit) && !tgt_ok) err_tgtid <= 1'b1;
  end
`endif

  sfifo #(
    .WIDTH ($bits(reqflit_t)),
    .DEPTH (NUM_CREDITS),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock   (clock),
    .rst_n   (rst_n),
    .wr_en   (flit_enq),
    .wr_data (rxreqflit),
    .rd_en   (pop),
    .rd_data (req_out),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_cnt)
  );

endmodule
